snake_collision_scan: RTL
=========================

Name: snake_collision_scan

Overview:
- Next-generation collision detector for the two-player snake game, sitting between the snake body registers and the game-control FSM.
- Each snake body is a packed vector of SEG_W-bit segments. Segment 0 is the head, and its low POS_W bits hold the grid position.
- One start request snapshots both bodies and their live lengths, then scans them sequentially (one segment index per cycle).
- Reports per-snake sticky collision flags, a head-on flag, and a done pulse. Adds variable length, self-collision and a handshake.

Parameters:
- MAX_SEG, 10, maximum segments per snake.
- SEG_W, 16, bit pitch of one segment in the packed body vector.
- POS_W, 10, position bits compared per segment (low bits of each segment, POS_W <= SEG_W).
- LEN_W, $clog2(MAX_SEG+1), width of length inputs. Derived; do not override.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous active-high reset
- start  input  1  scan request, sampled in IDLE only
- clear  input  1  clears sticky flags
- snake1  input  MAX_SEG*SEG_W  snake 1 body, segment i at [i*SEG_W +: POS_W]
- snake2  input  MAX_SEG*SEG_W  snake 2 body, same packing
- len1  input  LEN_W  live segment count of snake 1
- len2  input  LEN_W  live segment count of snake 2
- busy  output  1  high while in SCAN or DONE
- done  output  1  one-cycle pulse at end of scan
- hit1  output  1  sticky: snake 1 head collided (should stop)
- hit2  output  1  sticky: snake 2 head collided
- head_on  output  1  sticky: heads occupied the same cell

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE.
  - busy, done, hit1, hit2 and head_on all go to 0.
  - Scan index and per-scan accumulators go to 0.
  - Reset mid-scan aborts the scan with no done pulse.
- States: IDLE -> SCAN -> DONE -> IDLE.
- IDLE, start=1:
  - Latch snake1, snake2 and the clamped lengths L1 = min(len1, MAX_SEG), L2 = min(len2, MAX_SEG).
  - Set idx=0, clear the accumulators a1, a2 and ah, go to SCAN.
- SCAN: N = max(L1, L2, 1) cycles, idx = 0..N-1. Each cycle:
  - If L1>0, idx<L2 and idx>=0: head1 == snake2[idx] sets a1.
  - If L2>0, idx<L1: head2 == snake1[idx] sets a2.
  - At idx=0, with both L1 and L2 nonzero, head1 == head2 also sets ah.
  - When idx = N-1, go to DONE.
- A length-0 snake has no head. It generates no hit for itself but can still be collided with only if its length is >0, i.e. never.
- DONE, for one cycle:
  - done=1.
  - hit1 |= a1, hit2 |= a2, head_on |= ah.
  - Return to IDLE.
- Latency: start accepted at edge T; done high during cycle T+N+1. The next start is accepted no earlier than the cycle after done.
- start while busy is ignored (not queued). Inputs may change freely during the scan; only the snapshot is used.
- clear=1 zeroes hit1, hit2 and head_on on the next edge.
  - clear in the same cycle as DONE: the set wins (flags take the new accumulators).
  - clear does not affect an in-progress scan.
- Position compares use only the low POS_W bits of each segment. The upper SEG_W-POS_W bits are ignored.

Optional Feature:
- Macro SNAKE_SELF_COLLISION_EN.
- Defined: during SCAN, for 1 <= idx < L1, head1 == snake1[idx] sets a1. For 1 <= idx < L2, head2 == snake2[idx] sets a2. N is unchanged.
- Undefined: no self-compare logic; only cross-snake and head-on checks.

Test Plan:
- Reset then idle:
  - rst pulse, no start -> busy=0, done=0, hit1=hit2=head_on=0.
- Cross hit:
  - L1=3, L2=4, head1=0x055, snake2 segment 2=0x055, others distinct; start.
  - -> done exactly 5 cycles after the start edge (N=4), hit1=1, hit2=0, head_on=0.
- Head-on:
  - L1=L2=2, both heads 0x123 -> hit1=hit2=head_on=1.
  - clear one cycle later -> all three flags 0.
- Length boundaries:
  - len1=15 (clamped to 10), len2=0, head1 matches nothing -> N=10, no flags.
  - len1=len2=0 -> done 2 cycles after start, no flags.
- Busy/clear corner:
  - Start pulsed again mid-scan -> ignored; exactly one done.
  - clear asserted in the DONE cycle with a1=1 -> hit1=1 afterward.
  - rst mid-scan -> no done, flags 0.
- Self collision:
  - L1=5, snake1 segment 4 equals head1, snake2 disjoint.
  - -> hit1=1 with SNAKE_SELF_COLLISION_EN defined, hit1=0 without.

Source files
------------

// File: rtl/snake_collision_scan.sv
// Two-player snake collision scanner: snapshots both bodies on start and checks one segment index per cycle.
// Optional self-collision checks are compiled in with SNAKE_SELF_COLLISION_EN.
module snake_collision_scan #(
    parameter int MAX_SEG = 10,
    parameter int SEG_W   = 16,
    parameter int POS_W   = 10,
    localparam int LEN_W  = $clog2(MAX_SEG + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     clear,
    input  logic [MAX_SEG*SEG_W-1:0] snake1,
    input  logic [MAX_SEG*SEG_W-1:0] snake2,
    input  logic [LEN_W-1:0]         len1,
    input  logic [LEN_W-1:0]         len2,
    output logic                     busy,
    output logic                     done,
    output logic                     hit1,
    output logic                     hit2,
    output logic                     head_on
);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t                   state_q, state_d;
    logic [MAX_SEG*SEG_W-1:0] s1_q, s1_d, s2_q, s2_d;
    logic [LEN_W-1:0]         l1_q, l1_d, l2_q, l2_d;
    logic [LEN_W-1:0]         n_q, n_d, idx_q, idx_d;
    logic                     a1_q, a1_d, a2_q, a2_d, ah_q, ah_d;
    logic                     busy_q, busy_d, done_q, done_d;
    logic                     hit1_q, hit1_d, hit2_q, hit2_d, ho_q, ho_d;

    logic [LEN_W-1:0] l1_clamp, l2_clamp, n_start;
    logic [POS_W-1:0] pos1 [MAX_SEG];
    logic [POS_W-1:0] pos2 [MAX_SEG];
    logic [MAX_SEG-1:0] m12, m21, m11, m22, sel;
    logic cross1, cross2, self1, self2, head_match;

    assign l1_clamp = (len1 > LEN_W'(MAX_SEG)) ? LEN_W'(MAX_SEG) : len1;
    assign l2_clamp = (len2 > LEN_W'(MAX_SEG)) ? LEN_W'(MAX_SEG) : len2;
    assign n_start  = (l1_clamp == '0 && l2_clamp == '0) ? LEN_W'(1) :
                      (l1_clamp > l2_clamp) ? l1_clamp : l2_clamp;

    // Per-segment match vectors against each snapshot head; sel picks the current index.
    for (genvar gi = 0; gi < MAX_SEG; gi++) begin : g_seg
        assign pos1[gi] = s1_q[gi*SEG_W +: POS_W];
        assign pos2[gi] = s2_q[gi*SEG_W +: POS_W];
        assign m12[gi]  = (pos1[0] == pos2[gi]);
        assign m21[gi]  = (pos2[0] == pos1[gi]);
`ifdef SNAKE_SELF_COLLISION_EN
        if (gi == 0) begin : g_head
            assign m11[gi] = 1'b0;
            assign m22[gi] = 1'b0;
        end else begin : g_body
            assign m11[gi] = (pos1[0] == pos1[gi]);
            assign m22[gi] = (pos2[0] == pos2[gi]);
        end
`else
        assign m11[gi] = 1'b0;
        assign m22[gi] = 1'b0;
`endif
    end

    assign sel        = MAX_SEG'(1) << idx_q;
    assign cross1     = (l1_q != '0) && (idx_q < l2_q) && |(m12 & sel);
    assign cross2     = (l2_q != '0) && (idx_q < l1_q) && |(m21 & sel);
    assign self1      = (idx_q < l1_q) && |(m11 & sel);
    assign self2      = (idx_q < l2_q) && |(m22 & sel);
    assign head_match = (idx_q == '0) && (l1_q != '0) && (l2_q != '0) && (pos1[0] == pos2[0]);

    always_comb begin
        state_d = state_q;
        s1_d    = s1_q;
        s2_d    = s2_q;
        l1_d    = l1_q;
        l2_d    = l2_q;
        n_d     = n_q;
        idx_d   = idx_q;
        a1_d    = a1_q;
        a2_d    = a2_q;
        ah_d    = ah_q;
        done_d  = 1'b0;
        hit1_d  = clear ? 1'b0 : hit1_q;
        hit2_d  = clear ? 1'b0 : hit2_q;
        ho_d    = clear ? 1'b0 : ho_q;
        case (state_q)
            IDLE: begin
                // Hold off one cycle while done is visible so a new scan starts after it.
                if (start && !done_q) begin
                    s1_d    = snake1;
                    s2_d    = snake2;
                    l1_d    = l1_clamp;
                    l2_d    = l2_clamp;
                    n_d     = n_start;
                    idx_d   = '0;
                    a1_d    = 1'b0;
                    a2_d    = 1'b0;
                    ah_d    = 1'b0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                a1_d = a1_q | cross1 | self1;
                a2_d = a2_q | cross2 | self2;
                ah_d = ah_q | head_match;
                if (idx_q == n_q - LEN_W'(1)) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + LEN_W'(1);
                end
            end
            DONE: begin
                // Fresh results override a simultaneous clear.
                done_d  = 1'b1;
                hit1_d  = hit1_d | a1_q;
                hit2_d  = hit2_d | a2_q;
                ho_d    = ho_d | ah_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            s1_q    <= '0;
            s2_q    <= '0;
            l1_q    <= '0;
            l2_q    <= '0;
            n_q     <= '0;
            idx_q   <= '0;
            a1_q    <= 1'b0;
            a2_q    <= 1'b0;
            ah_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hit1_q  <= 1'b0;
            hit2_q  <= 1'b0;
            ho_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            l1_q    <= l1_d;
            l2_q    <= l2_d;
            n_q     <= n_d;
            idx_q   <= idx_d;
            a1_q    <= a1_d;
            a2_q    <= a2_d;
            ah_q    <= ah_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            hit1_q  <= hit1_d;
            hit2_q  <= hit2_d;
            ho_q    <= ho_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign hit1    = hit1_q;
    assign hit2    = hit2_q;
    assign head_on = ho_q;

endmodule
